uart_tx_param: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8N1 serialiser. Adds a programmable baud

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_param_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 72 +++++++
 rtl/uart_tx_param.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Shared UART definitions: FSM state encoding, parity modes, baud divisors.
// Rev 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Divisors for a 50 MHz system clock.
   localparam int CLKS_115200_50MHZ = 434;
   localparam int CLKS_9600_50MHZ   = 5208;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_param_if
// Producer-side handshake and TX status bundle for uart_tx_param.
// Rev 1.0 - initial release
// ============================================================================
interface uart_tx_param_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   logic [DATA_BITS-1:0]          data_in;
   logic                          valid_in;
   logic                          ready_out;
   logic                          serial_out;
   logic                          idle;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   modport master (
      output data_in, valid_in,
      input  ready_out, serial_out, idle, fifo_count
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, serial_out, idle, fifo_count
   );
endinterface : uart_tx_param_if
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// Synchronous FIFO with registered full flag and occupancy count.
// Rev 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic                     clock,
   input  wire logic                     reset,
   input  wire logic                     i_push,
   input  wire logic [WIDTH-1:0]         i_data,
   input  wire logic                     i_pop,
   output logic      [WIDTH-1:0]         o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic      [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [NW-1:0]    r_count;
   logic [NW-1:0]    w_next_count;
   logic             r_full;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & (r_count != '0);

   always_comb begin
      w_next_count = r_count;
      if (w_push && !w_pop)
         w_next_count = r_count + NW'(1);
      else if (!w_push && w_pop)
         w_next_count = r_count - NW'(1);
   end

   // Full is registered so ready only returns the cycle after a pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_next_count;
         r_full  <= (w_next_count == NW'(DEPTH));
      end
   end

   always_ff @(posedge clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_param
// Parametrised UART transmitter: input FIFO, baud divider, optional parity.
// Rev 1.0 - initial release
// ============================================================================
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = CLKS_115200_50MHZ,
   parameter int PARITY       = PARITY_NONE,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  wire logic        clock,
   input  wire logic        reset,
   uart_tx_param_if.slave   bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);

   if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("uart_tx_param: illegal parameter combination");
   end

   tx_state_t            r_state, w_state;
   logic [CW-1:0]        r_baud, w_baud;
   logic [IW-1:0]        r_bit_idx, w_bit_idx;
   logic [DATA_BITS-1:0] r_shift, w_shift;
   logic                 r_parity, w_parity;
   logic                 r_tx, w_tx;
   logic                 w_pop;
   logic                 w_bit_end;
   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_head;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (bus.valid_in),
      .i_data  (bus.data_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (bus.fifo_count)
   );

   assign w_bit_end = (r_baud == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state;
         r_baud    <= w_baud;
         r_bit_idx <= w_bit_idx;
         r_shift   <= w_shift;
         r_parity  <= w_parity;
         r_tx      <= w_tx;
      end
   end

   // w_tx is the line value for the bit period that starts at the next edge.
   always_comb begin
      w_state   = r_state;
      w_baud    = r_baud;
      w_bit_idx = r_bit_idx;
      w_shift   = r_shift;
      w_parity  = r_parity;
      w_tx      = r_tx;
      w_pop     = 1'b0;
      if (r_state != ST_IDLE)
         w_baud = w_bit_end ? '0 : r_baud + CW'(1);
      unique case (r_state)
         ST_IDLE: begin
            w_tx      = 1'b1;
            w_baud    = '0;
            w_bit_idx = '0;
            if (!w_empty) begin
               w_pop    = 1'b1;
               w_shift  = w_head;
               w_parity = (PARITY == PARITY_ODD);
               w_tx     = 1'b0;
               w_state  = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_state  = ST_DATA;
               w_tx     = r_shift[0];
               w_parity = r_parity ^ r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                  w_bit_idx = '0;
                  if (PARITY != PARITY_NONE) begin
                     w_state = ST_PARITY;
                     w_tx    = r_parity;
                  end else begin
                     w_state = ST_STOP;
                     w_tx    = 1'b1;
                  end
               end else begin
                  w_bit_idx = r_bit_idx + IW'(1);
                  w_shift   = r_shift >> 1;
                  w_tx      = r_shift[1];
                  w_parity  = r_parity ^ r_shift[1];
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               w_state = ST_STOP;
               w_tx    = 1'b1;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (r_bit_idx == IW'(STOP_BITS - 1)) begin
                  w_bit_idx = '0;
                  if (!w_empty) begin
                     w_pop    = 1'b1;
                     w_shift  = w_head;
                     w_parity = (PARITY == PARITY_ODD);
                     w_tx     = 1'b0;
                     w_state  = ST_START;
                  end else begin
                     w_state = ST_IDLE;
                     w_tx    = 1'b1;
                  end
               end else begin
                  w_bit_idx = r_bit_idx + IW'(1);
               end
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_tx    = 1'b1;
         end
      endcase
   end

   assign bus.ready_out  = ~w_full;
   assign bus.serial_out = r_tx;
   assign bus.idle       = (r_state == ST_IDLE) && w_empty;

endmodule : uart_tx_param
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_param
// Self-checking bench: four transmitter configurations against a frame model.
// Rev 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;
   localparam int CLKS = 4;
   // Per-instance configuration: 8N1, 8E2, 8O1, 5N2.
   localparam int DB  [4] = '{8, 8, 8, 5};
   localparam int PAR [4] = '{0, 1, 2, 0};
   localparam int SB  [4] = '{1, 2, 1, 2};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] tb_data  [4];
   logic       tb_valid [4];
   logic       tb_ready [4];
   logic       tb_tx    [4];
   logic       tb_idle  [4];
   logic [2:0] tb_count [4];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();
   uart_tx_param_if #(.DATA_BITS(5), .FIFO_DEPTH(4)) if3 ();

   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut0 (.clock(clk), .reset(rst), .bus(if0));
   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut1 (.clock(clk), .reset(rst), .bus(if1));
   uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CLKS), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      dut2 (.clock(clk), .reset(rst), .bus(if2));
   uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CLKS), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      dut3 (.clock(clk), .reset(rst), .bus(if3));

   assign if0.data_in = tb_data[0][7:0];
   assign if1.data_in = tb_data[1][7:0];
   assign if2.data_in = tb_data[2][7:0];
   assign if3.data_in = tb_data[3][4:0];
   assign if0.valid_in = tb_valid[0];
   assign if1.valid_in = tb_valid[1];
   assign if2.valid_in = tb_valid[2];
   assign if3.valid_in = tb_valid[3];
   assign tb_ready[0] = if0.ready_out;  assign tb_tx[0] = if0.serial_out;
   assign tb_ready[1] = if1.ready_out;  assign tb_tx[1] = if1.serial_out;
   assign tb_ready[2] = if2.ready_out;  assign tb_tx[2] = if2.serial_out;
   assign tb_ready[3] = if3.ready_out;  assign tb_tx[3] = if3.serial_out;
   assign tb_idle[0]  = if0.idle;       assign tb_count[0] = if0.fifo_count;
   assign tb_idle[1]  = if1.idle;       assign tb_count[1] = if1.fifo_count;
   assign tb_idle[2]  = if2.idle;       assign tb_count[2] = if2.fifo_count;
   assign tb_idle[3]  = if3.idle;       assign tb_count[3] = if3.fifo_count;

   // Offer each word until accepted; inputs change 2 time units after a rising edge.
   task automatic push_words(input int i, input logic [8:0] w[$]);
      bit acc;
      @(posedge clk); #2;
      foreach (w[k]) begin
         tb_valid[i] = 1'b1;
         tb_data[i]  = w[k];
         acc = 1'b0;
         for (int c = 0; c < 2000 && !acc; c++) begin
            @(negedge clk);
            acc = tb_ready[i];
            @(posedge clk); #2;
         end
         if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout dut%0d word %0d: ready=0 required 1", i, k);
         end
      end
      tb_valid[i] = 1'b0;
   endtask

   // Reference: each word becomes start, LSB-first data, optional parity, stop bits,
   // each held CLKS cycles; frames follow each other with no gap.
   task automatic check_stream(input int i, input logic [8:0] w[$], input string name);
      bit exp_bits[$];
      int ones;
      bit hit;
      int total;
      foreach (w[k]) begin
         exp_bits.push_back(1'b0);
         ones = 0;
         for (int b = 0; b < DB[i]; b++) begin
            exp_bits.push_back(w[k][b]);
            ones += int'(w[k][b]);
         end
         if (PAR[i] == 1) exp_bits.push_back(bit'(ones % 2));
         if (PAR[i] == 2) exp_bits.push_back(bit'(1 - ones % 2));
         for (int s = 0; s < SB[i]; s++) exp_bits.push_back(1'b1);
      end
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         if (tb_valid[i] && tb_ready[i]) hit = 1'b1;
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL %s_accept: accepted=0 required 1", name);
         return;
      end
      @(posedge clk);
      total = exp_bits.size() * CLKS;
      for (int n = 0; n < total; n++) begin
         @(posedge clk); #1;
         n_checks++;
         if (tb_tx[i] !== exp_bits[n / CLKS]) begin
            n_fail++;
            $display("FAIL %s_line cycle %0d: got %b required %b", name, n, tb_tx[i], exp_bits[n / CLKS]);
         end
         if (n == 0 || n == total - 1) begin
            n_checks++;
            if (tb_idle[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s_busy cycle %0d: idle=%b required 0", name, n, tb_idle[i]);
            end
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (tb_idle[i] !== 1'b1 || tb_tx[i] !== 1'b1 || tb_count[i] !== 3'd0) begin
         n_fail++;
         $display("FAIL %s_end: idle=%b line=%b count=%0d required idle=1 line=1 count=0",
                  name, tb_idle[i], tb_tx[i], tb_count[i]);
      end
   endtask

   task automatic one_frame(input int i, input logic [8:0] w, input string name);
      logic [8:0] q[$];
      q.push_back(w);
      fork
         check_stream(i, q, name);
         push_words(i, q);
      join
   endtask

   task automatic test_reset();
      logic [8:0] q[$];
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (tb_tx[i] !== 1'b1 || tb_idle[i] !== 1'b1 || tb_ready[i] !== 1'b1 || tb_count[i] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: line=%b idle=%b ready=%b count=%0d required 1 1 1 0",
                     i, tb_tx[i], tb_idle[i], tb_ready[i], tb_count[i]);
         end
      end
      @(posedge clk); #2;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) q.push_back(9'($urandom_range(0, 255)));
      push_words(0, q);
      n_checks++;
      if (tb_count[0] !== 3'd2) begin
         n_fail++;
         $display("FAIL reset_prefill: count=%0d required 2", tb_count[0]);
      end
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (tb_tx[0] !== 1'b1 || tb_idle[0] !== 1'b1 || tb_count[0] !== 3'd0 || tb_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_abort: line=%b idle=%b count=%0d ready=%b required 1 1 0 1",
                  tb_tx[0], tb_idle[0], tb_count[0], tb_ready[0]);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (tb_tx[0] !== 1'b1 || tb_idle[0] !== 1'b1 || tb_count[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_flush cycle %0d: line=%b idle=%b count=%0d required 1 1 0",
                     c, tb_tx[0], tb_idle[0], tb_count[0]);
         end
      end
   endtask

   task automatic test_8n1();
      one_frame(0, 9'h0A5, "8n1_a5");
      one_frame(0, 9'($urandom_range(0, 255)), "8n1_rand");
   endtask

   task automatic test_parity();
      one_frame(1, 9'h007, "even_07");
      one_frame(1, 9'($urandom_range(0, 255)), "even_rand");
      one_frame(2, 9'h007, "odd_07");
      one_frame(2, 9'($urandom_range(0, 255)), "odd_rand");
   endtask

   task automatic test_back_to_back();
      logic [8:0] q[$];
      q.push_back(9'h055); q.push_back(9'h0AA); q.push_back(9'h00F);
      fork
         check_stream(0, q, "b2b_fixed");
         push_words(0, q);
      join
      q.delete();
      for (int k = 0; k < 3; k++) q.push_back(9'($urandom_range(0, 255)));
      fork
         check_stream(0, q, "b2b_rand");
         push_words(0, q);
      join
   endtask

   task automatic test_full();
      logic [8:0] all[$];
      logic [8:0] first[$];
      logic [8:0] last[$];
      for (int k = 0; k < 6; k++) all.push_back(9'($urandom_range(0, 255)));
      for (int k = 0; k < 5; k++) first.push_back(all[k]);
      last.push_back(all[5]);
      fork
         check_stream(0, all, "full");
         begin
            push_words(0, first);
            n_checks++;
            if (tb_ready[0] !== 1'b0 || tb_count[0] !== 3'd4) begin
               n_fail++;
               $display("FAIL full_flag: ready=%b count=%0d required 0 4", tb_ready[0], tb_count[0]);
            end
            tb_valid[0] = 1'b1;
            tb_data[0]  = all[5];
            for (int c = 0; c < 5; c++) begin
               @(posedge clk); #2;
               n_checks++;
               if (tb_ready[0] !== 1'b0 || tb_count[0] !== 3'd4) begin
                  n_fail++;
                  $display("FAIL full_hold cycle %0d: ready=%b count=%0d required 0 4",
                           c, tb_ready[0], tb_count[0]);
               end
            end
            push_words(0, last);
         end
      join
   endtask

   task automatic test_width();
      one_frame(3, 9'h013, "w5_13");
      one_frame(3, 9'($urandom_range(0, 31)), "w5_rand");
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         tb_valid[i] = 1'b0;
         tb_data[i]  = '0;
      end
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_full();
      test_width();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_tx_param
`default_nettype wire
